// File: rtl/time_pkg.sv
// Shared BCD types, limits and helpers for the time_counter slice.
// bcd_ok is used by both the time load path and the alarm load path.
package time_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t SEC_MAX      = 8'h59;
  localparam bcd2_t MIN_MAX      = 8'h59;
  localparam bcd2_t HOUR_MAX_DEF = 8'h23;

  // BCD pair is legal and not above max.
  // Valid BCD orders the same way as binary.
  function automatic logic bcd_ok(
    input bcd2_t v,
    input bcd2_t max
  );
    return (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) &&
           (v <= max);
  endfunction

  function automatic bcd2_t bcd_inc(
    input bcd2_t v
  );
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/time_counter_bcd2_counter.sv
// Two-digit BCD counter, wraps max_val -> 00, load has priority.
// Ports: clk, rst_n, max_val, inc, load, load_val -> q, carry.
module bcd2_counter
  import time_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] max_val,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q,
  output logic       carry
);

  logic at_max;
  logic [7:0] nxt;

  assign at_max = (q == max_val);
  assign carry  = inc & at_max;

  always_comb begin
    nxt = q;
    if (load)
      nxt = load_val;
    else if (inc)
      nxt = at_max ? 8'h00 : bcd_inc(q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= 8'h00;
    else
      q <= nxt;
  end

endmodule

// File: rtl/time_counter.sv
// hh:mm:ss BCD time base ticked by rising edges of a synchronised clk_1Hz.
// Ports: clk, reset(n), clk_1Hz, set_en/set_hh/mm/ss -> hh, mm, ss, sec_tick,
// set_err. Define TIME_COUNTER_ALARM_EN for alarm_load/alarm_hh/alarm_mm/
// alarm_clr inputs and the alarm_on output.
module time_counter
  import time_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HOUR_MAX    = HOUR_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       set_en,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
`ifdef TIME_COUNTER_ALARM_EN
  input  logic       alarm_load,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_clr,
  output logic       alarm_on,
`endif
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_tick,
  output logic       set_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q;
  logic edge_q;
  logic set_ok;
  logic load_ok;
  logic tick;
  logic ss_carry;
  logic mm_carry;
  logic unused_hh_carry;
  logic err_d;

  // Edge is registered so the update lands on
  // the third clk edge after clk_1Hz is sampled high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_1Hz};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign set_ok = bcd_ok(set_ss, SEC_MAX) &&
                  bcd_ok(set_mm, MIN_MAX) &&
                  bcd_ok(set_hh, HOUR_MAX);
  assign load_ok = set_en & set_ok;
  // Any load strobe swallows a coincident tick.
  assign tick = edge_q & ~set_en;

  bcd2_counter u_ss (
    .clk      (clk),
    .rst_n    (reset),
    .max_val  (SEC_MAX),
    .inc      (tick),
    .load     (load_ok),
    .load_val (set_ss),
    .q        (ss),
    .carry    (ss_carry)
  );

  bcd2_counter u_mm (
    .clk      (clk),
    .rst_n    (reset),
    .max_val  (MIN_MAX),
    .inc      (ss_carry),
    .load     (load_ok),
    .load_val (set_mm),
    .q        (mm),
    .carry    (mm_carry)
  );

  bcd2_counter u_hh (
    .clk      (clk),
    .rst_n    (reset),
    .max_val  (HOUR_MAX),
    .inc      (mm_carry),
    .load     (load_ok),
    .load_val (set_hh),
    .q        (hh),
    .carry    (unused_hh_carry)
  );

`ifdef TIME_COUNTER_ALARM_EN
  logic [7:0] al_hh_q;
  logic [7:0] al_mm_q;
  logic al_ok;
  logic [7:0] mm_n;
  logic [7:0] hh_n;
  logic hit;

  assign al_ok = bcd_ok(alarm_mm, MIN_MAX) &&
                 bcd_ok(alarm_hh, HOUR_MAX);

  // Time after a tick that rolls seconds over.
  always_comb begin
    mm_n = mm_carry ? 8'h00 : bcd_inc(mm);
    hh_n = hh;
    if (mm_carry)
      hh_n = (hh == HOUR_MAX) ? 8'h00 : bcd_inc(hh);
  end

  always_comb begin
    hit = 1'b0;
    if (load_ok)
      hit = (set_ss == 8'h00) &&
            (set_mm == al_mm_q) &&
            (set_hh == al_hh_q);
    else if (ss_carry)
      hit = (mm_n == al_mm_q) &&
            (hh_n == al_hh_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      al_hh_q  <= 8'h00;
      al_mm_q  <= 8'h00;
      alarm_on <= 1'b0;
    end else begin
      if (alarm_load && al_ok) begin
        al_hh_q <= alarm_hh;
        al_mm_q <= alarm_mm;
      end
      if (alarm_clr)
        alarm_on <= 1'b0;
      else if (hit)
        alarm_on <= 1'b1;
    end
  end

  assign err_d = (set_en & ~set_ok) |
                 (alarm_load & ~al_ok);
`else
  assign err_d = set_en & ~set_ok;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_tick <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= tick;
      set_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: latency, wrap, load rules,
// load/tick collision, async reset and (optionally) the alarm.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_1Hz = 1'b0;
  logic       set_en = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;
  logic [7:0] hh, mm, ss;
  logic       sec_tick, set_err;
`ifdef TIME_COUNTER_ALARM_EN
  logic       alarm_load = 1'b0;
  logic [7:0] alarm_hh = 8'h00;
  logic [7:0] alarm_mm = 8'h00;
  logic       alarm_clr = 1'b0;
  logic       alarm_on;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int ticks;

  time_counter dut (
    .clk        (clk),
    .reset      (reset),
    .clk_1Hz    (clk_1Hz),
    .set_en     (set_en),
    .set_hh     (set_hh),
    .set_mm     (set_mm),
    .set_ss     (set_ss),
`ifdef TIME_COUNTER_ALARM_EN
    .alarm_load (alarm_load),
    .alarm_hh   (alarm_hh),
    .alarm_mm   (alarm_mm),
    .alarm_clr  (alarm_clr),
    .alarm_on   (alarm_on),
`endif
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .sec_tick   (sec_tick),
    .set_err    (set_err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(
    input logic [7:0] h,
    input logic [7:0] m,
    input logic [7:0] s
  );
    set_hh = h;
    set_mm = m;
    set_ss = s;
    set_en = 1'b1;
    step(1);
    set_en = 1'b0;
  endtask

  task automatic tick_up;
    clk_1Hz = 1'b1;
    step(4);
  endtask

  task automatic tick_dn;
    step(16);
    clk_1Hz = 1'b0;
    step(20);
  endtask

  function automatic logic [31:0] t3(
    input logic [7:0] h,
    input logic [7:0] m,
    input logic [7:0] s
  );
    return {8'h00, h, m, s};
  endfunction

  initial begin
    step(3);
    chk("rst_time", t3(hh, mm, ss), 32'h000000);
    chk("rst_tick", sec_tick, 0);
    chk("rst_err", set_err, 0);
    reset = 1'b1;
    step(5);

    // latency: edge 0 samples high, update on edge 3
    clk_1Hz = 1'b1;
    step(3);
    chk("lat_pre", ss, 8'h00);
    chk("lat_pre_tick", sec_tick, 0);
    step(1);
    chk("lat_ss", ss, 8'h01);
    chk("lat_tick", sec_tick, 1);
    step(1);
    chk("tick_1cyc", sec_tick, 0);
    step(495);
    clk_1Hz = 1'b0;
    step(500);

    // 100 kHz square wave: one tick per period
    ticks = 0;
    for (int p = 0; p < 4; p++) begin
      clk_1Hz = 1'b1;
      repeat (500) begin
        @(negedge clk);
        if (sec_tick) ticks++;
      end
      clk_1Hz = 1'b0;
      repeat (500) begin
        @(negedge clk);
        if (sec_tick) ticks++;
      end
    end
    chk("tick_cnt", ticks, 4);
    chk("cnt_time", t3(hh, mm, ss), 32'h000005);

    // full wrap in one update
    load(8'h23, 8'h59, 8'h58);
    chk("ld_time", t3(hh, mm, ss), 32'h235958);
    chk("ld_err", set_err, 0);
    tick_up;
    chk("wrap_a", t3(hh, mm, ss), 32'h235959);
    tick_dn;
    clk_1Hz = 1'b1;
    step(3);
    chk("wrap_pre", t3(hh, mm, ss), 32'h235959);
    step(1);
    chk("wrap_b", t3(hh, mm, ss), 32'h000000);
    chk("wrap_tick", sec_tick, 1);
    tick_dn;

    // rejected loads
    load(8'h12, 8'h60, 8'h00);
    chk("rej1_err", set_err, 1);
    chk("rej1_time", t3(hh, mm, ss), 32'h000000);
    step(1);
    chk("rej1_pulse", set_err, 0);
    load(8'h0A, 8'h00, 8'h00);
    chk("rej2_err", set_err, 1);
    chk("rej2_time", t3(hh, mm, ss), 32'h000000);
    step(1);
    chk("rej2_pulse", set_err, 0);
    load(8'h24, 8'h00, 8'h00);
    chk("rej3_err", set_err, 1);

    // load collides with tick update cycle
    clk_1Hz = 1'b1;
    step(3);
    load(8'h10, 8'h20, 8'h30);
    chk("col_time", t3(hh, mm, ss), 32'h102030);
    chk("col_tick", sec_tick, 0);
    tick_dn;
    tick_up;
    chk("col_next", t3(hh, mm, ss), 32'h102031);
    tick_dn;

    // async reset while clk_1Hz high
    clk_1Hz = 1'b1;
    step(10);
    load(8'h05, 8'h06, 8'h07);
    chk("mid_time", t3(hh, mm, ss), 32'h050607);
    #2 reset = 1'b0;
    #1;
    chk("async_rst", t3(hh, mm, ss), 32'h000000);
    step(3);
    reset = 1'b1;
    step(3);
    chk("rel_pre", ss, 8'h00);
    step(1);
    chk("rel_ss", ss, 8'h01);
    chk("rel_tick", sec_tick, 1);
    step(30);
    chk("rel_once", t3(hh, mm, ss), 32'h000001);
    clk_1Hz = 1'b0;
    step(20);

`ifdef TIME_COUNTER_ALARM_EN
    alarm_hh = 8'h24;
    alarm_mm = 8'h00;
    alarm_load = 1'b1;
    step(1);
    alarm_load = 1'b0;
    chk("al_rej", set_err, 1);
    alarm_hh = 8'h06;
    alarm_mm = 8'h30;
    alarm_load = 1'b1;
    step(1);
    alarm_load = 1'b0;
    chk("al_ld_err", set_err, 0);
    load(8'h06, 8'h29, 8'h59);
    chk("al_off", alarm_on, 0);
    tick_up;
    chk("al_time", t3(hh, mm, ss), 32'h063000);
    chk("al_on", alarm_on, 1);
    tick_dn;
    chk("al_hold", alarm_on, 1);
    alarm_clr = 1'b1;
    step(1);
    alarm_clr = 1'b0;
    chk("al_clr", alarm_on, 0);
    alarm_clr = 1'b1;
    load(8'h06, 8'h30, 8'h00);
    alarm_clr = 1'b0;
    chk("al_clr_win", alarm_on, 0);
    load(8'h06, 8'h30, 8'h00);
    chk("al_by_load", alarm_on, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Digital-clock time base that sits directly downstream of clock_generator and consumes its clk_1Hz output.
- Synchronises clk_1Hz into the clk domain and detects its rising edges.
- Keeps hh:mm:ss in packed BCD (24-hour), with a validated load path for setting the time.
- Outputs feed the display/seven-segment stage.

Parameters:
- SYNC_STAGES, 2, number of flops in the clk_1Hz synchroniser (minimum 2).
- HOUR_MAX, 8'h23, BCD value of the last hour before wrap to 8'h00.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- clk_1Hz  in  1  1 Hz square wave from clock_generator; asynchronous to the counter logic.
- set_en  in  1  one-cycle load strobe.
- set_hh  in  8  BCD hours to load.
- set_mm  in  8  BCD minutes to load.
- set_ss  in  8  BCD seconds to load.
- hh  out  8  BCD hours.
- mm  out  8  BCD minutes.
- ss  out  8  BCD seconds.
- sec_tick  out  1  one-cycle pulse on each cycle where the time advances.
- set_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=0): asynchronous and immediate, including mid-count or mid-load. hh, mm, ss = 8'h00; sec_tick = 0; set_err = 0; synchroniser and edge-history flops = 0.
- Edge detect: the last synchroniser stage is compared with a one-flop history. Sync=1 with history=0 is a rising edge, giving exactly one tick per clk_1Hz period.
- If clk_1Hz is already high when reset releases, that counts as one rising edge (one tick).
- Latency: with SYNC_STAGES=2, the first clk edge that samples clk_1Hz=1 is edge 0. ss and sec_tick update on clk edge 3 (2 sync + 1 detect/update).
- Falling edges of clk_1Hz have no effect.
- Increment on tick:
  - ss counts in BCD; low digit 9 -> 0 with carry into the high digit.
  - ss 8'h59 -> 8'h00 and mm increments.
  - mm 8'h59 -> 8'h00 and hh increments.
  - hh HOUR_MAX -> 8'h00.
  - All carries resolve in the same cycle, e.g. 23:59:59 -> 00:00:00 in one update.
- Load (set_en=1): the values are valid when every nibble is <= 9, set_ss <= 8'h59, set_mm <= 8'h59 and set_hh <= HOUR_MAX.
  - Valid: hh/mm/ss take the set values on the next clk edge.
  - Invalid: time is unchanged and set_err pulses for one cycle.
- Simultaneous load and tick: the load wins and the tick is discarded. sec_tick stays 0; the next tick increments from the loaded value.
- set_en held for multiple cycles: the load repeats every cycle, so time stays frozen at the set value while set_en=1.
- No internal state machine beyond the counters; all outputs are registered.

Optional Feature:
- Macro: TIME_COUNTER_ALARM_EN.
- When defined, adds these ports:
  - alarm_load (in, 1): loads the alarm time.
  - alarm_hh (in, 8) and alarm_mm (in, 8): BCD alarm time, validated by the same rules as the load path. Invalid values are ignored; set_err pulses.
  - alarm_clr (in, 1): clears alarm_on.
  - alarm_on (out, 1): alarm indicator.
- alarm_on sets on the update cycle where the time becomes alarm_hh:alarm_mm:00, whether by a tick or by a valid load.
- alarm_on stays set until alarm_clr=1 or reset. If set and clear occur in the same cycle, clear wins.
- Alarm registers reset to 8'h00 / 8'h00.
- When the macro is not defined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package time_pkg holds:
  - the 8-bit BCD pair typedef;
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX_DEF=8'h23;
  - a BCD-range check function used by both the load and alarm paths.
- Sub-module bcd2_counter: two-digit BCD counter with MAX input, inc, load, load_val, and carry-out (asserted when inc and value==MAX).
  - Instantiated three times (ss, mm, hh), chained by carry-out.
- Synchroniser and edge detect stay inline in time_counter.

Test Plan:
- Reset with clk_1Hz=0, release, then toggle clk_1Hz at 100 kHz (sped up) -> hh:mm:ss = 00:00:00 after reset; ss = 01 exactly 3 clk edges after the first high sample; one sec_tick per rising edge.
- Load 23:59:58, then 2 ticks -> 23:59:59 then 00:00:00; the wrap happens in a single update cycle.
- Load 12:60:00 and then 0A:00:00 -> both rejected; set_err pulses one cycle each; time unchanged.
- Assert set_en=1 (load 10:20:30) on the same cycle a tick would update -> time = 10:20:30; sec_tick=0; next tick gives 10:20:31.
- Assert reset mid-count at 05:06:07 with clk_1Hz high -> outputs go to 0 immediately, without waiting for clk; after release, exactly one tick gives 00:00:01.
- With TIME_COUNTER_ALARM_EN: alarm 06:30, load 06:29:59, one tick -> alarm_on=1 at 06:30:00; it holds until alarm_clr; set and clear in the same cycle -> 0.
